memory_stage: RTL and testbench
===============================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have reset_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have ir3_output, pc3_output, z3_output, md3_output  input  32 each  execute-stage instruction, PC, ALU result/address, store data.
REQ-004 SHALL have valid3  input  1  execute-stage contents are a real instruction.
REQ-005 SHALL have flush  input  1  discard the instruction offered this cycle.
REQ-006 SHALL have dmem_req, dmem_we  output  1 each  data-memory request and write enable.
REQ-007 SHALL have dmem_addr, dmem_wdata  output  32 each  data-memory address and write data.
REQ-008 SHALL have dmem_ready  input  1, and dmem_rdata  input  32  memory completion strobe and load data.
REQ-009 SHALL have ir4_output, pc4_output, z4_output, md4_output, read_data  output  32 each  registered values consumed by writeback.
REQ-010 SHALL have valid4, stall, misalign_err  output  1 each  writeback-valid, upstream hold, alignment fault pulse.

Function
REQ-011 SHALL decode the opcode from ir3_output[31:26]: LW = 6'b100011, SW = 6'b101011; any other opcode is non-memory.
REQ-012 SHALL be a two-state FSM: IDLE and ACCESS.
REQ-013 SHALL, in IDLE with valid3=1, flush=0 and a non-memory opcode, load ir4/pc4/z4/md4 from ir3/pc3/z3/md3 with valid4=1 on the next edge (1-cycle latency) and keep stall=0.
REQ-014 SHALL, in IDLE with valid3=0 or flush=1, drive valid4=0 on the next edge and leave ir4/pc4/z4/md4/read_data unchanged.
REQ-015 SHALL, in IDLE with an aligned memory op (z3_output[1:0]=0), valid3=1 and flush=0, assert stall combinationally in that cycle.
REQ-016 SHALL, in the case of REQ-015, register dmem_addr=z3_output, dmem_wdata=md3_output and dmem_we=1 for SW or 0 for LW, set dmem_req=1, capture ir3/pc3/z3/md3 internally, and enter ACCESS on the next edge.
REQ-017 SHALL hold dmem_req, dmem_we, dmem_addr and dmem_wdata stable and keep stall=1 for every ACCESS cycle, including the completion cycle.
REQ-018 SHALL drive valid4=0 on every edge where the FSM stays in ACCESS.
REQ-019 SHALL, on an edge in ACCESS with dmem_ready=1: load the captured instruction into ir4/pc4/z4/md4, set read_data=dmem_rdata for LW (unchanged for SW), set valid4=1, clear dmem_req and dmem_we, and return to IDLE.
REQ-020 SHALL take at least 2 cycles per memory instruction, and SHALL accept the next instruction in the cycle after completion.
REQ-021 SHALL ignore flush while in ACCESS (a started transaction always completes), and SHALL ignore dmem_ready while in IDLE.
REQ-022 SHALL, for a memory op in IDLE with z3_output[1:0]!=0, valid3=1 and flush=0: issue no request, keep stall=0, drive valid4=0 and pulse misalign_err=1 for exactly one cycle on the next edge.
REQ-023 SHALL give flush priority over misalignment (no misalign_err when flush=1).

Reset
REQ-024 SHALL, while reset_n=0 regardless of clk, force FSM=IDLE and all registered outputs to 0: ir4/pc4/z4/md4/read_data=32'h0, valid4=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, misalign_err=0.
REQ-025 SHALL abandon an ACCESS in progress on reset, with no completion reported after reset_n rises.
REQ-026 SHALL deassert stall during reset.

Structure
REQ-027 SHALL take the LW/SW opcode constants and the FSM state encoding from the shared processor package, which is also used by the decode and writeback stages.
REQ-028 SHALL use one natural sub-module, stage_reg4 (a 4x32-bit load-enabled pipeline register bank); all other logic SHALL be in memory_stage.

Verification
REQ-029 SHALL cover ADD (opcode 0) with pc3=0x40, z3=0x7 and valid3=1 -> next cycle ir4 equals the ADD word, pc4=0x40, z4=0x7, valid4=1, stall=0.
REQ-030 SHALL cover LW with z3=0x100 and dmem_ready held low 3 cycles then high, rdata=0xDEADBEEF -> dmem_req=1 with addr=0x100 and we=0 for 4 cycles, stall=1, valid4=0 throughout; then read_data=0xDEADBEEF and valid4=1.
REQ-031 SHALL cover SW with z3=0x20, md3=0x55 and dmem_ready high on the first ACCESS cycle -> dmem_we=1 and wdata=0x55 for 1 cycle; valid4=1 two edges after issue; read_data unchanged.
REQ-032 SHALL cover LW with z3=0x102 -> misalign_err=1 for one cycle, dmem_req stays 0, valid4=0, stall=0.
REQ-033 SHALL cover flush=1 asserted in the second ACCESS cycle -> the transaction still completes with valid4=1; flush=1 with an ADD in IDLE -> valid4=0.
REQ-034 SHALL cover reset_n pulsed low mid-ACCESS -> all outputs 0 immediately (asynchronously), FSM in IDLE, and no valid4 after release.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// Shared processor definitions: memory opcodes, memory-stage FSM encoding and
// the four-lane pipeline bank layout used between execute, memory and writeback.
package memory_stage_pkg;

  localparam int XLEN      = 32;
  localparam int NUM_LANES = 4;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  // Lane order inside a pipeline bank, most significant lane first.
  localparam int LANE_IR = 3;
  localparam int LANE_PC = 2;
  localparam int LANE_Z  = 1;
  localparam int LANE_MD = 0;

  typedef logic [NUM_LANES-1:0][XLEN-1:0] stage_bank_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/stage_reg4.sv
// Load-enabled bank of four 32-bit pipeline registers, cleared by reset.
module stage_reg4
  import memory_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  stage_bank_t d,
  output stage_bank_t q
);

  for (genvar lane = 0; lane < NUM_LANES; lane++) begin : g_lane
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  q[lane] <= '0;
      else if (load) q[lane] <= d[lane];
    end
  end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: passes non-memory instructions through in one cycle and
// runs LW/SW as a stalled request/ready transaction against data memory.
module memory_stage
  import memory_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] ir3_output,
  input  logic [XLEN-1:0] pc3_output,
  input  logic [XLEN-1:0] z3_output,
  input  logic [XLEN-1:0] md3_output,
  input  logic            valid3,
  input  logic            flush,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] ir4_output,
  output logic [XLEN-1:0] pc4_output,
  output logic [XLEN-1:0] z4_output,
  output logic [XLEN-1:0] md4_output,
  output logic [XLEN-1:0] read_data,
  output logic            valid4,
  output logic            stall,
  output logic            misalign_err
);

  mem_state_t  state;
  stage_bank_t in_bank, cap_q, out_d, out_q;

  logic [5:0] opcode;
  logic       take, mem_op, aligned, pass, issue, misalign, complete, cap_lw;

  assign opcode   = ir3_output[31:26];
  assign mem_op   = is_mem_op(opcode);
  assign aligned  = (z3_output[1:0] == 2'b00);
  assign take     = (state == IDLE) && valid3 && !flush;
  assign pass     = take && !mem_op;
  assign issue    = take && mem_op && aligned;
  assign misalign = take && mem_op && !aligned;
  assign complete = (state == ACCESS) && dmem_ready;
  assign cap_lw   = (cap_q[LANE_IR][31:26] == OP_LW);

  // Stall covers the issue cycle combinationally; forced low while in reset.
  assign stall = reset_n && (issue || (state == ACCESS));

  assign in_bank[LANE_IR] = ir3_output;
  assign in_bank[LANE_PC] = pc3_output;
  assign in_bank[LANE_Z]  = z3_output;
  assign in_bank[LANE_MD] = md3_output;

  assign out_d = complete ? cap_q : in_bank;

  stage_reg4 u_cap (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (issue),
    .d       (in_bank),
    .q       (cap_q)
  );

  stage_reg4 u_out (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (pass || complete),
    .d       (out_d),
    .q       (out_q)
  );

  assign ir4_output = out_q[LANE_IR];
  assign pc4_output = out_q[LANE_PC];
  assign z4_output  = out_q[LANE_Z];
  assign md4_output = out_q[LANE_MD];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      valid4       <= 1'b0;
      misalign_err <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      read_data    <= '0;
    end else begin
      misalign_err <= 1'b0;
      case (state)
        IDLE: begin
          valid4       <= pass;
          misalign_err <= misalign;
          if (issue) begin
            dmem_req   <= 1'b1;
            dmem_we    <= (opcode == OP_SW);
            dmem_addr  <= z3_output;
            dmem_wdata <= md3_output;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          // flush is deliberately not looked at here: a started access always completes.
          valid4 <= complete;
          if (complete) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (cap_lw) read_data <= dmem_rdata;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Randomized scoreboard bench for memory_stage: driver pushes expected writeback,
// misalign and memory-request events; independent monitors pop and compare.
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] ir3_output = '0, pc3_output = '0, z3_output = '0, md3_output = '0;
  logic        valid3 = 1'b0, flush = 1'b0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic [31:0] ir4_output, pc4_output, z4_output, md4_output, read_data;
  logic        valid4, stall, misalign_err;

  memory_stage dut (
    .clk(clk), .reset_n(reset_n),
    .ir3_output(ir3_output), .pc3_output(pc3_output), .z3_output(z3_output), .md3_output(md3_output),
    .valid3(valid3), .flush(flush),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .ir4_output(ir4_output), .pc4_output(pc4_output), .z4_output(z4_output), .md4_output(md4_output),
    .read_data(read_data), .valid4(valid4), .stall(stall), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          mis;
    logic [31:0] ir, pc, z, md, rd;
  } exp_t;

  typedef struct {
    logic [31:0] addr, wdata;
    logic        we;
  } req_t;

  exp_t        outq[$];
  req_t        reqq[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] m_rd = '0;   // model of the writeback read_data register

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (cyc > 50000) begin
      bad++;
      $display("FAIL watchdog actual=%0d required<=50000 cycles", cyc);
      $fatal(1, "watchdog");
    end
  end

  // Memory-request monitor: one expected request per rising dmem_req.
  bit prev_req = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) prev_req = 1'b0;
    else begin
      if (dmem_req && !prev_req) begin
        if (reqq.size() == 0) chk("req_unexpected", 32'd1, 32'd0);
        else begin
          req_t r;
          r = reqq.pop_front();
          chk("req_addr", dmem_addr, r.addr);
          chk("req_wdata", dmem_wdata, r.wdata);
          chk("req_we", {31'd0, dmem_we}, {31'd0, r.we});
        end
      end
      prev_req = dmem_req;
    end
  end

  // Writeback / misalign monitor.
  always @(negedge clk) begin
    if (reset_n && (valid4 || misalign_err)) begin
      if (outq.size() == 0) chk("out_unexpected", {30'd0, valid4, misalign_err}, 32'd0);
      else begin
        exp_t e;
        e = outq.pop_front();
        chk("out_kind", {30'd0, valid4, misalign_err}, e.mis ? 32'd1 : 32'd2);
        if (!e.mis) begin
          chk("wb_ir", ir4_output, e.ir);
          chk("wb_pc", pc4_output, e.pc);
          chk("wb_z", z4_output, e.z);
          chk("wb_md", md4_output, e.md);
          chk("wb_rd", read_data, e.rd);
        end
      end
    end
  end

  // Offer one instruction; for an aligned memory op run the access with
  // lat not-ready cycles, junk on the inputs, and optional flush in the second cycle.
  task automatic issue(input logic [31:0] ir, pc, z, md, input bit v, fl,
                       input int lat, input logic [31:0] rd, input bit fl_mid);
    bit   lw, sw, mem, ok, acc;
    exp_t e;
    req_t r;
    lw  = (ir[31:26] == OP_LW);
    sw  = (ir[31:26] == OP_SW);
    mem = lw || sw;
    ok  = v && !fl;
    acc = ok && mem && (z[1:0] == 2'b00);
    @(negedge clk);
    ir3_output = ir; pc3_output = pc; z3_output = z; md3_output = md;
    valid3 = v; flush = fl;
    dmem_ready = 1'($urandom_range(0, 1));
    dmem_rdata = $urandom;
    if (ok && !mem) begin
      e = '{mis: 1'b0, ir: ir, pc: pc, z: z, md: md, rd: m_rd};
      outq.push_back(e);
    end
    if (ok && mem && !acc) begin
      e = '{mis: 1'b1, ir: 0, pc: 0, z: 0, md: 0, rd: 0};
      outq.push_back(e);
    end
    if (acc) begin
      r = '{addr: z, wdata: md, we: sw};
      reqq.push_back(r);
    end
    #1 chk("stall_issue", {31'd0, stall}, {31'd0, acc});
    @(posedge clk); #1;
    chk("valid4_next", {31'd0, valid4}, {31'd0, ok && !mem});
    chk("misalign_next", {31'd0, misalign_err}, {31'd0, ok && mem && !acc});
    if (ok && mem && !acc) chk("misalign_noreq", {31'd0, dmem_req}, 32'd0);
    if (acc) begin
      for (int i = 0; i <= lat; i++) begin
        @(negedge clk);
        ir3_output = $urandom; z3_output = $urandom;
        valid3 = 1'($urandom_range(0, 1));
        flush  = (fl_mid && i == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        dmem_ready = (i == lat);
        dmem_rdata = (i == lat) ? rd : $urandom;
        if (i == lat) begin
          if (lw) m_rd = rd;
          e = '{mis: 1'b0, ir: ir, pc: pc, z: z, md: md, rd: m_rd};
          outq.push_back(e);
        end
        #1;
        chk("acc_stall", {31'd0, stall}, 32'd1);
        chk("acc_req", {31'd0, dmem_req}, 32'd1);
        chk("acc_addr", dmem_addr, z);
        chk("acc_we", {31'd0, dmem_we}, {31'd0, sw});
        if (sw) chk("acc_wdata", dmem_wdata, md);
      end
      @(posedge clk); #1;
      chk("valid4_done", {31'd0, valid4}, 32'd1);
      chk("req_cleared", {30'd0, dmem_req, dmem_we}, 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ir4"}, ir4_output, 0);
    chk({tag, "_pc4"}, pc4_output, 0);
    chk({tag, "_z4"}, z4_output, 0);
    chk({tag, "_md4"}, md4_output, 0);
    chk({tag, "_rd"}, read_data, 0);
    chk({tag, "_addr"}, dmem_addr, 0);
    chk({tag, "_wdata"}, dmem_wdata, 0);
    chk({tag, "_bits"}, {27'd0, valid4, dmem_req, dmem_we, misalign_err, stall}, 0);
  endtask

  logic [31:0] lw_w, sw_w, add_w, rnd, zr, irr;

  initial begin
    lw_w  = {OP_LW, 5'd1, 5'd2, 16'h0100};
    sw_w  = {OP_SW, 5'd1, 5'd3, 16'h0020};
    add_w = 32'h00221820;

    #1 reset_n = 1'b0;
    valid3 = 1'b1; ir3_output = lw_w; z3_output = 32'h100;   // stall must still be 0
    #22 check_all_zero("reset");
    valid3 = 1'b0;
    @(negedge clk); reset_n = 1'b1;

    // Directed cases.
    issue(add_w, 32'h40, 32'h7, 32'h0, 1, 0, 0, 0, 0);
    issue(lw_w, 32'h44, 32'h100, 32'h0, 1, 0, 3, 32'hDEADBEEF, 0);
    issue(sw_w, 32'h48, 32'h20, 32'h55, 1, 0, 0, 0, 0);
    issue(lw_w, 32'h4C, 32'h102, 32'h0, 1, 0, 0, 0, 0);
    issue(lw_w, 32'h50, 32'h200, 32'h0, 1, 0, 2, 32'h12345678, 1);
    issue(add_w, 32'h54, 32'h9, 32'h1, 1, 1, 0, 0, 0);
    issue(lw_w, 32'h58, 32'h103, 32'h0, 1, 1, 0, 0, 0);

    // Reset in the middle of an access.
    @(negedge clk);
    ir3_output = lw_w; pc3_output = 32'h60; z3_output = 32'h300; valid3 = 1'b1; flush = 1'b0;
    dmem_ready = 1'b0;
    reqq.push_back('{addr: 32'h300, wdata: md3_output, we: 1'b0});
    @(negedge clk);
    valid3 = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_all_zero("midreset");
    dmem_ready = 1'b1;
    @(negedge clk); #2 reset_n = 1'b1;
    m_rd = '0;
    repeat (3) @(negedge clk);
    dmem_ready = 1'b0;
    chk("post_reset_idle", {30'd0, valid4, stall}, 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      rnd = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          irr = $urandom;
          while (is_mem_op(irr[31:26])) irr = $urandom;
        end
        4, 5, 6: irr = {OP_LW, rnd[25:0]};
        default: irr = {OP_SW, rnd[25:0]};
      endcase
      zr = $urandom;
      if ($urandom_range(0, 3) != 0) zr[1:0] = 2'b00;
      issue(irr, $urandom, zr, $urandom, $urandom_range(0, 5) != 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 4), $urandom, 1'($urandom_range(0, 1)));
    end

    @(negedge clk); valid3 = 1'b0; flush = 1'b0; dmem_ready = 1'b0;
    repeat (4) @(negedge clk);
    chk("outq_drained", outq.size(), 0);
    chk("reqq_drained", reqq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
